// File: rtl/fetch_pkg.sv
// Shared definitions for the RV32I fetch stage: datapath width, instruction
// size, FSM state encoding and the target alignment test.
// Latency: n/a (definitions only). Backpressure: n/a.
package fetch_pkg;

    localparam int XLEN = 32;

    // Byte size of one RV32I instruction; no compressed instructions exist.
    localparam logic [XLEN-1:0] INSN_BYTES = 32'd4;

    typedef enum logic [2:0] {
        ST_REQ,
        ST_WAIT,
        ST_HOLD,
        ST_DRAIN,
        ST_FAULT
    } state_t;

    // A fetch target is legal only on a 4-byte boundary.
    function automatic logic is_aligned(input logic [1:0] addr_lo);
        return addr_lo == 2'b00;
    endfunction

endpackage

// File: rtl/fetch.sv
// RV32I fetch stage: owns the PC, fetches one word at a time, buffers it for decode.
// Latency: >=3 cycles per insn (REQ -> WAIT -> HOLD) with a zero-wait memory.
// Backpressure: insn_ready low holds the buffered insn and stops fetching; one request max in flight.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   imem_req/addr/gnt                request channel to instruction memory
//   imem_rvalid/rdata                response channel from instruction memory
//   redirect/redirect_pc             PC redirect from execute, highest priority
//   insn_valid/ready, insn, insn_pc  handshake and payload towards decode
//   fetch_fault                      sticky flag: redirect target was misaligned
module fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        insn_valid,
    input  logic        insn_ready,
    output logic [31:0] insn,
    output logic [31:0] insn_pc,
    output logic        fetch_fault
);

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic [31:0] pc_nxt;
    logic        hold_vld;     // registered copy of (state == ST_HOLD)
    logic        gnt_ok;
    logic        redir_ok;
    logic        redir_bad;
    logic        capture;

    // A grant only counts while a request is actually being driven; right
    // after reset the request flop is still low.
    assign gnt_ok    = imem_req & imem_gnt;
    assign redir_ok  = redirect & is_aligned(redirect_pc[1:0]);
    assign redir_bad = redirect & ~is_aligned(redirect_pc[1:0]);

    // Redirect kills the buffered insn combinationally so decode never
    // accepts a wrong-path word in the redirect cycle.
    assign insn_valid = hold_vld & ~redirect;
    assign imem_addr  = pc;

    // A response is kept only when no redirect of any kind arrives with it.
    assign capture = (state == ST_WAIT) & imem_rvalid & ~redirect;

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;

        case (state)
            ST_REQ:   if (gnt_ok) state_nxt = ST_WAIT;
            ST_WAIT:  if (imem_rvalid) begin
                          state_nxt = ST_HOLD;
                          pc_nxt    = pc + INSN_BYTES;
                      end
            ST_HOLD:  if (insn_ready) state_nxt = ST_REQ;
            ST_DRAIN: if (imem_rvalid) state_nxt = ST_REQ;
            ST_FAULT: state_nxt = ST_FAULT;
            default:  state_nxt = ST_REQ;
        endcase

        // Redirect overrides normal progress everywhere except FAULT.
        if (state != ST_FAULT) begin
            if (redir_bad) begin
                state_nxt = ST_FAULT;
                pc_nxt    = pc;
            end else if (redir_ok) begin
                pc_nxt = redirect_pc;
                case (state)
                    // Ungranted request: simply retarget the pending request.
                    ST_REQ:   state_nxt = gnt_ok ? ST_DRAIN : ST_REQ;
                    // A wrong-path response is still owed unless it is here now.
                    ST_WAIT:  state_nxt = imem_rvalid ? ST_REQ : ST_DRAIN;
                    ST_HOLD:  state_nxt = ST_REQ;
                    ST_DRAIN: state_nxt = imem_rvalid ? ST_REQ : ST_DRAIN;
                    default:  state_nxt = ST_FAULT;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_REQ;
            pc          <= RESET_PC;
            imem_req    <= 1'b0;
            hold_vld    <= 1'b0;
            insn        <= 32'h0;
            insn_pc     <= 32'h0;
            fetch_fault <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            imem_req <= (state_nxt == ST_REQ);
            hold_vld <= (state_nxt == ST_HOLD);
            if (capture) begin
                insn    <= imem_rdata;
                insn_pc <= pc;
            end
            if (redir_bad && (state != ST_FAULT)) begin
                fetch_fault <= 1'b1;
            end
        end
    end

endmodule
